// File: rtl/zero_cross_period_meter_pkg.sv
// Shared definitions for the zero-crossing period meter.
//   state_t            : ST_ACQUIRE / ST_TRACK tracking state encoding
//   HYST_DEFAULT       : default arming threshold magnitude
//   MAX_PERIOD_DEFAULT : default loss-of-signal timeout, quarter-sample units
//   IDX_W / NUM_SUB    : sub-sample index width and sub-samples per clock
package zero_cross_period_meter_pkg;

  typedef enum logic [0:0] {
    ST_ACQUIRE = 1'b0,
    ST_TRACK   = 1'b1
  } state_t;

  localparam int HYST_DEFAULT       = 64;
  localparam int MAX_PERIOD_DEFAULT = 16000;
  localparam int IDX_W              = 2;
  localparam int NUM_SUB            = 4;

endpackage

// File: rtl/zc_subsample_scan.sv
// Combinational rising zero-crossing scan over the four sub-samples of one clock.
// Ports:
//   sub0..sub3 : sub-samples in time order (signed two's complement, DW bits)
//   armed_in   : armed state carried in from the previous clock
//   hit        : a crossing occurred in this sample set
//   idx        : index of the earliest crossing (valid when hit)
//   armed_out  : armed state after sub-sample 3, carried to the next clock
module zc_subsample_scan
  import zero_cross_period_meter_pkg::*;
#(
  parameter int DW   = 14,
  parameter int HYST = HYST_DEFAULT
) (
  input  logic [DW-1:0]    sub0,
  input  logic [DW-1:0]    sub1,
  input  logic [DW-1:0]    sub2,
  input  logic [DW-1:0]    sub3,
  input  logic             armed_in,
  output logic             hit,
  output logic [IDX_W-1:0] idx,
  output logic             armed_out
);

  localparam logic signed [DW-1:0] NEG_HYST = DW'(-HYST);

  logic [DW-1:0] subs [NUM_SUB];

  assign subs[0] = sub0;
  assign subs[1] = sub1;
  assign subs[2] = sub2;
  assign subs[3] = sub3;

  // Walk the sub-samples in time order. Only the earliest crossing fires; later
  // sub-samples may still re-arm so the next clock can catch the following edge.
  always_comb begin
    hit       = 1'b0;
    idx       = '0;
    armed_out = armed_in;
    for (int i = 0; i < NUM_SUB; i++) begin
      if (armed_out && !subs[i][DW-1] && !hit) begin
        hit       = 1'b1;
        idx       = IDX_W'(i);
        armed_out = 1'b0;
      end else if ($signed(subs[i]) < NEG_HYST) begin
        armed_out = 1'b1;
      end
    end
  end

endmodule

// File: rtl/zero_cross_period_meter.sv
// Zero-crossing period meter: measures the interval between rising zero
// crossings (with hysteresis) in quarter-sample units and flags loss of signal.
// Optional feature macro: ZC_PERIOD_AVG4_EN (output the mean of the last four
// periods instead of the raw period).
// Ports:
//   clk325kHz_d1 : sample clock, all logic on posedge
//   reset        : synchronous, active-high
//   x1, x1d25, x1d5, x1d75 : sub-samples at t = k, k+0.25, k+0.5, k+0.75
//   period       : last measured (or averaged) period, quarter-sample units
//   period_valid : one-cycle pulse when period updates
//   locked       : high while tracking after at least one period output
//   lost         : one-cycle pulse on timeout
module zero_cross_period_meter
  import zero_cross_period_meter_pkg::*;
#(
  parameter int DW         = 14,
  parameter int PW         = 16,
  parameter int HYST       = HYST_DEFAULT,
  parameter int MAX_PERIOD = MAX_PERIOD_DEFAULT
) (
  input  logic          clk325kHz_d1,
  input  logic          reset,
  input  logic [DW-1:0] x1,
  input  logic [DW-1:0] x1d25,
  input  logic [DW-1:0] x1d5,
  input  logic [DW-1:0] x1d75,
  output logic [PW-1:0] period,
  output logic          period_valid,
  output logic          locked,
  output logic          lost
);

  localparam logic [PW-1:0] MAX_P = PW'(MAX_PERIOD);

  state_t           state;
  logic             armed;
  logic [PW-1:0]    cnt;

  logic             hit;
  logic [IDX_W-1:0] idx;
  logic             armed_next;

  logic [PW-1:0]    meas;
  logic [PW-1:0]    cnt_plus4;
  logic [PW-1:0]    cnt_restart;

  zc_subsample_scan #(
    .DW   (DW),
    .HYST (HYST)
  ) u_scan (
    .sub0      (x1),
    .sub1      (x1d25),
    .sub2      (x1d5),
    .sub3      (x1d75),
    .armed_in  (armed),
    .hit       (hit),
    .idx       (idx),
    .armed_out (armed_next)
  );

  // cnt is the distance from the last crossing to sub-sample 0 of this clock.
  assign meas        = cnt + PW'(idx);
  assign cnt_plus4   = cnt + PW'(4);
  assign cnt_restart = PW'(4) - PW'(idx);

`ifdef ZC_PERIOD_AVG4_EN
  // hist holds the three periods preceding the one being measured now.
  logic [PW-1:0] hist [3];
  logic [1:0]    hist_n;
  logic [PW+1:0] avg_sum;

  assign avg_sum = {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]} + {2'b00, meas};
`endif

  always_ff @(posedge clk325kHz_d1) begin
    if (reset) begin
      state        <= ST_ACQUIRE;
      armed        <= 1'b0;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      lost         <= 1'b0;
`ifdef ZC_PERIOD_AVG4_EN
      hist_n       <= '0;
      for (int i = 0; i < 3; i++) hist[i] <= '0;
`endif
    end else begin
      period_valid <= 1'b0;
      lost         <= 1'b0;
      armed        <= armed_next;
      case (state)
        ST_ACQUIRE: begin
          if (hit) begin
            cnt   <= cnt_restart;
            state <= ST_TRACK;
          end else begin
            cnt <= '0;
          end
        end
        ST_TRACK: begin
          // A crossing takes priority over a timeout in the same clock.
          if (hit) begin
            cnt <= cnt_restart;
`ifdef ZC_PERIOD_AVG4_EN
            hist[0] <= meas;
            hist[1] <= hist[0];
            hist[2] <= hist[1];
            if (hist_n == 2'd3) begin
              period       <= avg_sum[PW+1:2];
              period_valid <= 1'b1;
              locked       <= 1'b1;
            end else begin
              hist_n <= hist_n + 2'd1;
            end
`else
            period       <= meas;
            period_valid <= 1'b1;
            locked       <= 1'b1;
`endif
          end else if (cnt_plus4 > MAX_P) begin
            lost   <= 1'b1;
            locked <= 1'b0;
            armed  <= 1'b0;
            cnt    <= '0;
            state  <= ST_ACQUIRE;
`ifdef ZC_PERIOD_AVG4_EN
            hist_n <= '0;
            for (int i = 0; i < 3; i++) hist[i] <= '0;
`endif
          end else begin
            cnt <= cnt_plus4;
          end
        end
        default: state <= ST_ACQUIRE;
      endcase
    end
  end

endmodule

// File: tb/tb_zero_cross_period_meter.sv
// Directed self-checking bench for zero_cross_period_meter.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same
// point, so they reflect the sample set applied just before the edge.
module tb_zero_cross_period_meter;

  localparam int DW = 14;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] x1, x1d25, x1d5, x1d75;
  logic [PW-1:0] period;
  logic          period_valid;
  logic          locked;
  logic          lost;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nvalid = 0, nlost = 0;
  int valid_cyc = 0, lost_cyc = 0, valid_gap = 0, last_period = 0;

  always #5 clk = ~clk;

  zero_cross_period_meter #(
    .DW (DW),
    .PW (PW)
  ) dut (
    .clk325kHz_d1 (clk),
    .reset        (reset),
    .x1           (x1),
    .x1d25        (x1d25),
    .x1d5         (x1d5),
    .x1d75        (x1d75),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .lost         (lost)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one sample set, clock it, then record output events.
  task automatic step(input int a, input int b, input int c, input int d);
    x1    = DW'(a);
    x1d25 = DW'(b);
    x1d5  = DW'(c);
    x1d75 = DW'(d);
    @(posedge clk);
    #1;
    cyc++;
    if (period_valid) begin
      nvalid++;
      valid_gap   = cyc - valid_cyc;
      valid_cyc   = cyc;
      last_period = int'(period);
    end
    if (lost) begin
      nlost++;
      lost_cyc = cyc;
    end
  endtask

  task automatic flat(input int v, input int n);
    repeat (n) step(v, v, v, v);
  endtask

  task automatic square(input int n);
    repeat (n) begin
      flat(-1000, 20);
      flat(1000, 20);
    end
  endtask

  task automatic clr();
    nvalid = 0;
    nlost  = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flat(0, 2);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    x1 = '0; x1d25 = '0; x1d5 = '0; x1d75 = '0;
    flat(0, 3);
    check_val("rst_period", int'(period), 0);
    check_val("rst_valid", int'(period_valid), 0);
    check_val("rst_locked", int'(locked), 0);
    check_val("rst_lost", int'(lost), 0);
    reset = 1'b0;

`ifdef ZC_PERIOD_AVG4_EN
    // Crossings 160, 164, 156, 160 then 168 quarter-units apart.
    clr();
    flat(-1000, 5);
    flat(1000, 1);
    flat(-1000, 39); flat(1000, 1);
    flat(-1000, 40); flat(1000, 1);
    flat(-1000, 38); flat(1000, 1);
    check_val("avg_early_nvalid", nvalid, 0);
    check_val("avg_early_locked", int'(locked), 0);
    flat(-1000, 39); flat(1000, 1);
    check_val("avg_first_nvalid", nvalid, 1);
    check_val("avg_first_period", last_period, 160);
    check_val("avg_first_locked", int'(locked), 1);
    flat(-1000, 41); flat(1000, 1);
    check_val("avg_next_nvalid", nvalid, 2);
    check_val("avg_next_period", last_period, 162);
    check_val("avg_hold_port", int'(period), 162);
`else
    // Square wave, 40 clocks per cycle, sub-samples equal.
    clr();
    square(3);
    check_val("sq_nvalid", nvalid, 2);
    check_val("sq_period", last_period, 160);
    check_val("sq_gap", valid_gap, 40);
    check_val("sq_locked", int'(locked), 1);

    // Crossing at sub-sample 2, then at sub-sample 1 ten clocks later.
    do_reset();
    clr();
    flat(-1000, 4);
    step(-500, -200, 100, 400);
    flat(-1000, 9);
    step(-300, 200, 500, 800);
    check_val("ramp_nvalid", nvalid, 1);
    check_val("ramp_period", last_period, 39);
    flat(800, 1);
    check_val("ramp_pulse_width", int'(period_valid), 0);

    // Small toggles around zero: only the first rise after arming counts.
    clr();
    flat(-1000, 1);
    repeat (50) step(30, -30, 30, -30);
    check_val("hyst_nvalid", nvalid, 1);
    check_val("hyst_period", last_period, 11);

    // Timeout: lost fires 4000 clocks after the last crossing.
    do_reset();
    clr();
    square(2);
    check_val("to_pre_nvalid", nvalid, 1);
    clr();
    flat(-1000, 4001);
    check_val("to_nlost", nlost, 1);
    check_val("to_when", lost_cyc - valid_cyc, 4000);
    check_val("to_nvalid", nvalid, 0);
    check_val("to_locked", int'(locked), 0);
    check_val("to_period", int'(period), 160);
    clr();
    square(2);
    check_val("resume_nvalid", nvalid, 1);
    check_val("resume_period", last_period, 160);
    check_val("resume_locked", int'(locked), 1);

    // Reset coincident with a crossing while tracking.
    flat(-1000, 20);
    reset = 1'b1;
    step(1000, 1000, 1000, 1000);
    check_val("mid_rst_valid", int'(period_valid), 0);
    check_val("mid_rst_period", int'(period), 0);
    check_val("mid_rst_locked", int'(locked), 0);
    check_val("mid_rst_lost", int'(lost), 0);
    reset = 1'b0;
    clr();
    flat(1000, 5);
    square(2);
    check_val("post_rst_nvalid", nvalid, 1);
    check_val("post_rst_period", last_period, 160);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
